// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, key-schedule FSM encoding and word/byte helpers.
package aes_pkg;
    localparam int AES_NK      = 4;
    localparam int AES_NR      = 10;
    localparam int AES_BLOCK_W = 128;

    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // RotWord: byte 0 (MSB) moves to the least significant byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);
    always_comb begin
        o_out = 8'h00;
        case (i_in)
            8'h00: o_out = 8'h63; 8'h01: o_out = 8'h7c; 8'h02: o_out = 8'h77; 8'h03: o_out = 8'h7b; 8'h04: o_out = 8'hf2; 8'h05: o_out = 8'h6b; 8'h06: o_out = 8'h6f; 8'h07: o_out = 8'hc5;
            8'h08: o_out = 8'h30; 8'h09: o_out = 8'h01; 8'h0a: o_out = 8'h67; 8'h0b: o_out = 8'h2b; 8'h0c: o_out = 8'hfe; 8'h0d: o_out = 8'hd7; 8'h0e: o_out = 8'hab; 8'h0f: o_out = 8'h76;
            8'h10: o_out = 8'hca; 8'h11: o_out = 8'h82; 8'h12: o_out = 8'hc9; 8'h13: o_out = 8'h7d; 8'h14: o_out = 8'hfa; 8'h15: o_out = 8'h59; 8'h16: o_out = 8'h47; 8'h17: o_out = 8'hf0;
            8'h18: o_out = 8'had; 8'h19: o_out = 8'hd4; 8'h1a: o_out = 8'ha2; 8'h1b: o_out = 8'haf; 8'h1c: o_out = 8'h9c; 8'h1d: o_out = 8'ha4; 8'h1e: o_out = 8'h72; 8'h1f: o_out = 8'hc0;
            8'h20: o_out = 8'hb7; 8'h21: o_out = 8'hfd; 8'h22: o_out = 8'h93; 8'h23: o_out = 8'h26; 8'h24: o_out = 8'h36; 8'h25: o_out = 8'h3f; 8'h26: o_out = 8'hf7; 8'h27: o_out = 8'hcc;
            8'h28: o_out = 8'h34; 8'h29: o_out = 8'ha5; 8'h2a: o_out = 8'he5; 8'h2b: o_out = 8'hf1; 8'h2c: o_out = 8'h71; 8'h2d: o_out = 8'hd8; 8'h2e: o_out = 8'h31; 8'h2f: o_out = 8'h15;
            8'h30: o_out = 8'h04; 8'h31: o_out = 8'hc7; 8'h32: o_out = 8'h23; 8'h33: o_out = 8'hc3; 8'h34: o_out = 8'h18; 8'h35: o_out = 8'h96; 8'h36: o_out = 8'h05; 8'h37: o_out = 8'h9a;
            8'h38: o_out = 8'h07; 8'h39: o_out = 8'h12; 8'h3a: o_out = 8'h80; 8'h3b: o_out = 8'he2; 8'h3c: o_out = 8'heb; 8'h3d: o_out = 8'h27; 8'h3e: o_out = 8'hb2; 8'h3f: o_out = 8'h75;
            8'h40: o_out = 8'h09; 8'h41: o_out = 8'h83; 8'h42: o_out = 8'h2c; 8'h43: o_out = 8'h1a; 8'h44: o_out = 8'h1b; 8'h45: o_out = 8'h6e; 8'h46: o_out = 8'h5a; 8'h47: o_out = 8'ha0;
            8'h48: o_out = 8'h52; 8'h49: o_out = 8'h3b; 8'h4a: o_out = 8'hd6; 8'h4b: o_out = 8'hb3; 8'h4c: o_out = 8'h29; 8'h4d: o_out = 8'he3; 8'h4e: o_out = 8'h2f; 8'h4f: o_out = 8'h84;
            8'h50: o_out = 8'h53; 8'h51: o_out = 8'hd1; 8'h52: o_out = 8'h00; 8'h53: o_out = 8'hed; 8'h54: o_out = 8'h20; 8'h55: o_out = 8'hfc; 8'h56: o_out = 8'hb1; 8'h57: o_out = 8'h5b;
            8'h58: o_out = 8'h6a; 8'h59: o_out = 8'hcb; 8'h5a: o_out = 8'hbe; 8'h5b: o_out = 8'h39; 8'h5c: o_out = 8'h4a; 8'h5d: o_out = 8'h4c; 8'h5e: o_out = 8'h58; 8'h5f: o_out = 8'hcf;
            8'h60: o_out = 8'hd0; 8'h61: o_out = 8'hef; 8'h62: o_out = 8'haa; 8'h63: o_out = 8'hfb; 8'h64: o_out = 8'h43; 8'h65: o_out = 8'h4d; 8'h66: o_out = 8'h33; 8'h67: o_out = 8'h85;
            8'h68: o_out = 8'h45; 8'h69: o_out = 8'hf9; 8'h6a: o_out = 8'h02; 8'h6b: o_out = 8'h7f; 8'h6c: o_out = 8'h50; 8'h6d: o_out = 8'h3c; 8'h6e: o_out = 8'h9f; 8'h6f: o_out = 8'ha8;
            8'h70: o_out = 8'h51; 8'h71: o_out = 8'ha3; 8'h72: o_out = 8'h40; 8'h73: o_out = 8'h8f; 8'h74: o_out = 8'h92; 8'h75: o_out = 8'h9d; 8'h76: o_out = 8'h38; 8'h77: o_out = 8'hf5;
            8'h78: o_out = 8'hbc; 8'h79: o_out = 8'hb6; 8'h7a: o_out = 8'hda; 8'h7b: o_out = 8'h21; 8'h7c: o_out = 8'h10; 8'h7d: o_out = 8'hff; 8'h7e: o_out = 8'hf3; 8'h7f: o_out = 8'hd2;
            8'h80: o_out = 8'hcd; 8'h81: o_out = 8'h0c; 8'h82: o_out = 8'h13; 8'h83: o_out = 8'hec; 8'h84: o_out = 8'h5f; 8'h85: o_out = 8'h97; 8'h86: o_out = 8'h44; 8'h87: o_out = 8'h17;
            8'h88: o_out = 8'hc4; 8'h89: o_out = 8'ha7; 8'h8a: o_out = 8'h7e; 8'h8b: o_out = 8'h3d; 8'h8c: o_out = 8'h64; 8'h8d: o_out = 8'h5d; 8'h8e: o_out = 8'h19; 8'h8f: o_out = 8'h73;
            8'h90: o_out = 8'h60; 8'h91: o_out = 8'h81; 8'h92: o_out = 8'h4f; 8'h93: o_out = 8'hdc; 8'h94: o_out = 8'h22; 8'h95: o_out = 8'h2a; 8'h96: o_out = 8'h90; 8'h97: o_out = 8'h88;
            8'h98: o_out = 8'h46; 8'h99: o_out = 8'hee; 8'h9a: o_out = 8'hb8; 8'h9b: o_out = 8'h14; 8'h9c: o_out = 8'hde; 8'h9d: o_out = 8'h5e; 8'h9e: o_out = 8'h0b; 8'h9f: o_out = 8'hdb;
            8'ha0: o_out = 8'he0; 8'ha1: o_out = 8'h32; 8'ha2: o_out = 8'h3a; 8'ha3: o_out = 8'h0a; 8'ha4: o_out = 8'h49; 8'ha5: o_out = 8'h06; 8'ha6: o_out = 8'h24; 8'ha7: o_out = 8'h5c;
            8'ha8: o_out = 8'hc2; 8'ha9: o_out = 8'hd3; 8'haa: o_out = 8'hac; 8'hab: o_out = 8'h62; 8'hac: o_out = 8'h91; 8'had: o_out = 8'h95; 8'hae: o_out = 8'he4; 8'haf: o_out = 8'h79;
            8'hb0: o_out = 8'he7; 8'hb1: o_out = 8'hc8; 8'hb2: o_out = 8'h37; 8'hb3: o_out = 8'h6d; 8'hb4: o_out = 8'h8d; 8'hb5: o_out = 8'hd5; 8'hb6: o_out = 8'h4e; 8'hb7: o_out = 8'ha9;
            8'hb8: o_out = 8'h6c; 8'hb9: o_out = 8'h56; 8'hba: o_out = 8'hf4; 8'hbb: o_out = 8'hea; 8'hbc: o_out = 8'h65; 8'hbd: o_out = 8'h7a; 8'hbe: o_out = 8'hae; 8'hbf: o_out = 8'h08;
            8'hc0: o_out = 8'hba; 8'hc1: o_out = 8'h78; 8'hc2: o_out = 8'h25; 8'hc3: o_out = 8'h2e; 8'hc4: o_out = 8'h1c; 8'hc5: o_out = 8'ha6; 8'hc6: o_out = 8'hb4; 8'hc7: o_out = 8'hc6;
            8'hc8: o_out = 8'he8; 8'hc9: o_out = 8'hdd; 8'hca: o_out = 8'h74; 8'hcb: o_out = 8'h1f; 8'hcc: o_out = 8'h4b; 8'hcd: o_out = 8'hbd; 8'hce: o_out = 8'h8b; 8'hcf: o_out = 8'h8a;
            8'hd0: o_out = 8'h70; 8'hd1: o_out = 8'h3e; 8'hd2: o_out = 8'hb5; 8'hd3: o_out = 8'h66; 8'hd4: o_out = 8'h48; 8'hd5: o_out = 8'h03; 8'hd6: o_out = 8'hf6; 8'hd7: o_out = 8'h0e;
            8'hd8: o_out = 8'h61; 8'hd9: o_out = 8'h35; 8'hda: o_out = 8'h57; 8'hdb: o_out = 8'hb9; 8'hdc: o_out = 8'h86; 8'hdd: o_out = 8'hc1; 8'hde: o_out = 8'h1d; 8'hdf: o_out = 8'h9e;
            8'he0: o_out = 8'he1; 8'he1: o_out = 8'hf8; 8'he2: o_out = 8'h98; 8'he3: o_out = 8'h11; 8'he4: o_out = 8'h69; 8'he5: o_out = 8'hd9; 8'he6: o_out = 8'h8e; 8'he7: o_out = 8'h94;
            8'he8: o_out = 8'h9b; 8'he9: o_out = 8'h1e; 8'hea: o_out = 8'h87; 8'heb: o_out = 8'he9; 8'hec: o_out = 8'hce; 8'hed: o_out = 8'h55; 8'hee: o_out = 8'h28; 8'hef: o_out = 8'hdf;
            8'hf0: o_out = 8'h8c; 8'hf1: o_out = 8'ha1; 8'hf2: o_out = 8'h89; 8'hf3: o_out = 8'h0d; 8'hf4: o_out = 8'hbf; 8'hf5: o_out = 8'he6; 8'hf6: o_out = 8'h42; 8'hf7: o_out = 8'h68;
            8'hf8: o_out = 8'h41; 8'hf9: o_out = 8'h99; 8'hfa: o_out = 8'h2d; 8'hfb: o_out = 8'h0f; 8'hfc: o_out = 8'hb0; 8'hfd: o_out = 8'h54; 8'hfe: o_out = 8'hbb; 8'hff: o_out = 8'h16;
            default: o_out = 8'h00;
        endcase
    end
endmodule

// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: iterative AES-128 key schedule, one round key per clock,
// all 11 round keys presented packed on expanded_key once exp_valid is high.
import aes_pkg::*;

module aes_key_expand_seq #(
    parameter int KEY_W      = AES_BLOCK_W,
    parameter int NUM_ROUNDS = AES_NR
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             key_valid,
    output logic                             key_ready,
    input  logic [KEY_W-1:0]                 key,
    output logic [(NUM_ROUNDS+1)*KEY_W-1:0]  expanded_key,
    output logic                             exp_valid,
    output logic                             busy
);
    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic [7:0]         r_rcon;
    logic [KEY_W-1:0]   r_prev;
    logic [31:0]        w_rot, w_sub, w_temp, w_w0, w_w1, w_w2, w_w3;

    assign w_rot = rot_word(r_prev[31:0]);

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_sbox
            aes_sbox u_sbox (.i_in(w_rot[8*g +: 8]), .o_out(w_sub[8*g +: 8]));
        end
    endgenerate

    assign w_temp = w_sub ^ {r_rcon, 24'h0};
    assign w_w0   = r_prev[127:96] ^ w_temp;
    assign w_w1   = r_prev[95:64]  ^ w_w0;
    assign w_w2   = r_prev[63:32]  ^ w_w1;
    assign w_w3   = r_prev[31:0]   ^ w_w2;

    always_ff @(posedge clk) begin
        if (rst) begin
            expanded_key <= '0;
            exp_valid    <= 1'b0;
            busy         <= 1'b0;
            key_ready    <= 1'b1;
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_rcon       <= 8'h01;
            r_prev       <= '0;
        end else if (key_valid && key_ready) begin
            expanded_key[NUM_ROUNDS*KEY_W +: KEY_W] <= key;
            r_prev    <= key;
            r_cnt     <= 4'd1;
            r_rcon    <= 8'h01;
            r_state   <= ST_EXPAND;
            exp_valid <= 1'b0;
            busy      <= 1'b1;
            key_ready <= 1'b0;
        end else if (r_state == ST_EXPAND) begin
            // Slot r lives at [KEY_W*(NUM_ROUNDS-r) +: KEY_W]; only this slot changes per cycle.
            expanded_key[KEY_W*(NUM_ROUNDS-int'(r_cnt)) +: KEY_W] <= {w_w0, w_w1, w_w2, w_w3};
            r_prev <= {w_w0, w_w1, w_w2, w_w3};
            r_rcon <= xtime(r_rcon);
            r_cnt  <= (r_cnt == LAST) ? 4'd0 : r_cnt + 4'd1;
            if (r_cnt == LAST) begin
                r_state   <= ST_DONE;
                exp_valid <= 1'b1;
                busy      <= 1'b0;
                key_ready <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_aes_key_expand_seq.sv
// tb_aes_key_expand_seq: scoreboard bench with a GF(2^8)-arithmetic key schedule model.
module tb_aes_key_expand_seq;
    logic           clk = 1'b0;
    logic           rst, key_valid, key_ready, exp_valid, busy;
    logic [127:0]   key;
    logic [1407:0]  expanded_key;

    aes_key_expand_seq dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready), .key(key),
        .expanded_key(expanded_key), .exp_valid(exp_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int             n_cmp = 0, n_bad = 0, cyc = 0;
    bit             acc_flag = 1'b0, prev_ev = 1'b0;
    logic [7:0]     sb [256];
    logic [1407:0]  exp_q [$];
    int             t_q [$];

    localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_SYS = 128'h100F0E0D0C0B0A090807060504030201;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00, x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    function automatic logic [7:0] sbox_math(input logic [7:0] x);
        logic [7:0] v = 8'h00;
        for (int y = 1; y < 256; y++)
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) v = 8'(y);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [1407:0] ref_expand(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1407:0] r;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) r[32*(43-i) +: 32] = w[i];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string nm, input logic [1407:0] act, input logic [1407:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            for (int i = 10; i >= 0; i--)
                if (act[128*i +: 128] !== req[128*i +: 128]) begin
                    $display("FAIL %s (slot %0d): got %h required %h", nm, 10 - i, act[128*i +: 128], req[128*i +: 128]);
                    break;
                end
        end
    endtask

    // Stimulus side of the scoreboard: every accepted key queues its expected schedule.
    always @(posedge clk) begin
        cyc = cyc + 1;
        acc_flag = 1'b0;
        if (rst) begin
            exp_q.delete();
            t_q.delete();
        end else if (key_valid && key_ready) begin
            exp_q.push_back(ref_expand(key));
            t_q.push_back(cyc);
            acc_flag = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (acc_flag) chk("accept_flags", 1408'({exp_valid, busy, key_ready}), 1408'(3'b010));
        if (exp_valid && !prev_ev) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_exp_valid: got 1 required 0");
            end else begin
                chk("schedule", expanded_key, exp_q.pop_front());
                chk("latency", 1408'(cyc - t_q.pop_front()), 1408'(10));
                chk("done_flags", 1408'({busy, key_ready}), 1408'(2'b01));
            end
        end else if (t_q.size() > 0 && cyc - t_q[0] > 10) begin
            n_cmp++;
            n_bad++;
            $display("FAIL exp_valid_timeout: got 0 required 1");
            void'(exp_q.pop_front());
            void'(t_q.pop_front());
        end
        prev_ev = exp_valid;
    end

    task automatic send(input logic [127:0] k);
        key = k;
        key_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (key_ready) begin
                @(negedge clk);
                key_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        key_valid = 1'b0;
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: got key_ready 0 required 1");
    endtask

    task automatic wait_done();
        for (int n = 0; n < 30; n++) begin
            if (exp_valid) return;
            @(negedge clk);
        end
        n_cmp++;
        n_bad++;
        $display("FAIL done_timeout: got exp_valid 0 required 1");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) sb[i] = sbox_math(8'(i));
        rst = 1'b1;
        key_valid = 1'b0;
        key = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_key", expanded_key, '0);
        chk("reset_flags", 1408'({exp_valid, busy, key_ready}), 1408'(3'b001));
        send(KEY_A1);
        wait_done();
        chk("a1_rk1", 1408'(expanded_key[1279 -: 128]), 1408'(128'ha0fafe1788542cb123a339392a6c7605));
        chk("a1_rk10", 1408'(expanded_key[127:0]), 1408'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        send(128'h0);
        wait_done();
        chk("zero_rk1", 1408'(expanded_key[1279 -: 128]), 1408'(128'h62636363626363636263636362636363));
        chk("zero_rk10", 1408'(expanded_key[127:0]), 1408'(128'hb4ef5bcb3e92e21123e951cf6f8f188e));
        // Hold key_valid with a changing key through EXPAND, then back-to-back accept from DONE.
        key = KEY_A1;
        key_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk("ready_low", 1408'(key_ready), 1408'(0));
            key = rnd128();
            @(negedge clk);
        end
        chk("ready_done", 1408'({key_ready, exp_valid}), 1408'(2'b11));
        @(negedge clk);
        key_valid = 1'b0;
        wait_done();
        send(KEY_A1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_key", expanded_key, '0);
        chk("midrst_flags", 1408'({exp_valid, busy, key_ready}), 1408'(3'b001));
        send(KEY_A1);
        wait_done();
        chk("post_rst_rk10", 1408'(expanded_key[127:0]), 1408'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
        key = rnd128();
        key_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        key_valid = 1'b0;
        chk("rst_wins_key", expanded_key, '0);
        chk("rst_wins_flags", 1408'({exp_valid, busy, key_ready}), 1408'(3'b001));
        send(KEY_SYS);
        wait_done();
        for (int i = 0; i < 6; i++) send(rnd128());
        wait_done();
        for (int n = 0; n < 30 && exp_q.size() > 0; n++) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
